// File: rtl/crop_stream_framer_pkg.sv
// rtl/crop_stream_framer_pkg.sv - shared pixel width default and frame flag bundle
package crop_stream_framer_pkg;

  localparam int PIXEL_BIT_WIDTH_DEF = 12;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } frame_flags_t;

  function automatic frame_flags_t make_flags(input logic row_first, input logic row_last,
                                              input logic col_first, input logic col_last);
    frame_flags_t f;
    f.sof = row_first && col_first;
    f.eol = col_last;
    f.eof = col_last && row_last;
    return f;
  endfunction

endpackage

// File: rtl/crop_stream_framer_if.sv
// rtl/crop_stream_framer_if.sv - cropped pixel stream in/out handshake bundle
interface crop_stream_framer_if
  import crop_stream_framer_pkg::*;
#(
  parameter int PW = PIXEL_BIT_WIDTH_DEF
);

  logic [PW-1:0] pixel_in;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] pixel_out;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;

  modport slave (
    input  pixel_in, in_valid, out_ready,
    output in_ready, pixel_out, out_valid, out_sof, out_eol, out_eof
  );

  modport master (
    output pixel_in, in_valid, out_ready,
    input  in_ready, pixel_out, out_valid, out_sof, out_eol, out_eof
  );

endinterface

// File: rtl/crop_stream_framer_fifo.sv
// rtl/crop_stream_framer_fifo.sv - first-word fall-through register FIFO with level output
module pixel_sync_fifo
  import crop_stream_framer_pkg::*;
#(
  parameter int WIDTH = PIXEL_BIT_WIDTH_DEF,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               wr_data_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  output logic [WIDTH-1:0]               rd_data_o,
  output logic                           rd_valid_o,
  input  logic                           rd_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty, full, wr_fire, rd_fire;

  // Extra MSB on each pointer distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign wr_ready_o = !full && rst_n;
  assign rd_valid_o = !empty;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o    = LW'(wr_ptr_q - rd_ptr_q);

  assign wr_fire = wr_valid_i && wr_ready_o;
  assign rd_fire = rd_valid_o && rd_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/crop_stream_framer.sv
// rtl/crop_stream_framer.sv - buffers the cropped stream and tags pixels with sof/eol/eof
module crop_stream_framer
  import crop_stream_framer_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = PIXEL_BIT_WIDTH_DEF,
  parameter int OUT_ROWS        = 20,
  parameter int OUT_COLS        = 20,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  crop_stream_framer_if.slave               stream,
  output logic [15:0]                       frame_count,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_ROWS - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          rd_fire;
  frame_flags_t  flags;

  pixel_sync_fifo #(
    .WIDTH (PIXEL_BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .wr_data_i  (stream.pixel_in),
    .wr_valid_i (stream.in_valid),
    .wr_ready_o (stream.in_ready),
    .rd_data_o  (stream.pixel_out),
    .rd_valid_o (stream.out_valid),
    .rd_ready_i (stream.out_ready),
    .level_o    (fifo_level)
  );

  assign rd_fire = stream.out_valid && stream.out_ready;

  // Coordinates describe the head pixel, so they only move when that pixel is consumed.
  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    frame_count_d = frame_count_q;
    if (rd_fire) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d         = '0;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_count_q <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign flags = make_flags(row_q == '0, row_q == ROW_LAST, col_q == '0, col_q == COL_LAST);

  assign stream.out_sof = flags.sof;
  assign stream.out_eol = flags.eol;
  assign stream.out_eof = flags.eof;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_crop_stream_framer.sv
// tb/tb_crop_stream_framer.sv - directed and randomised-handshake checks of crop_stream_framer
module tb_crop_stream_framer;

  localparam int PW    = 12;
  localparam int ROWS  = 20;
  localparam int COLS  = 20;
  localparam int DEPTH = 8;
  localparam int FRAME = ROWS * COLS;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] frame_count;
  logic [3:0]  fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  int out_idx  = 0;
  int seq      = 0;
  int mon_pos;
  logic [PW-1:0] exp_pix;
  logic [PW-1:0] exp_q[$];
  bit drv_done;

  crop_stream_framer_if #(.PW(PW)) sif ();

  crop_stream_framer #(
    .PIXEL_BIT_WIDTH (PW),
    .OUT_ROWS        (ROWS),
    .OUT_COLS        (COLS),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stream      (sif.slave),
    .frame_count (frame_count),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pix_of(input int n);
    return PW'(n * 37 + 5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PW-1:0] pix, input int gap_pct);
    int guard = 0;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      sif.in_valid = 1'b0;
      step();
    end
    sif.pixel_in = pix;
    sif.in_valid = 1'b1;
    while (!sif.in_ready && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check_eq("send_timeout", guard, 0);
    step();
    sif.in_valid = 1'b0;
  endtask

  task automatic send_seq(input int count, input int gap_pct);
    for (int i = 0; i < count; i++) begin
      send(pix_of(seq), gap_pct);
      seq++;
    end
  endtask

  task automatic wait_out(input int target, input int budget);
    int g = 0;
    while (out_idx < target && g < budget) begin
      step();
      g++;
    end
    check_eq("drain_count", out_idx, target);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    out_idx = 0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Scoreboard sampled on the falling edge, i.e. the handshake the next rising edge will take.
  always @(negedge clk) begin
    if (reset_n) begin
      check_eq("level_max", 32'(fifo_level <= 4'(DEPTH)), 1);
      if (sif.out_valid && sif.out_ready) begin
        mon_pos = out_idx % FRAME;
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", exp_q.size(), 1);
        end else begin
          exp_pix = exp_q.pop_front();
          check_eq("pixel", sif.pixel_out, exp_pix);
          check_eq("sof", sif.out_sof, mon_pos == 0);
          check_eq("eol", sif.out_eol, (mon_pos % COLS) == COLS - 1);
          check_eq("eof", sif.out_eof, mon_pos == FRAME - 1);
        end
        out_idx++;
      end
      if (sif.in_valid && sif.in_ready) exp_q.push_back(sif.pixel_in);
    end
  end

  initial begin
    sif.pixel_in  = '0;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", sif.out_valid, 0);
    check_eq("rst_in_ready", sif.in_ready, 0);
    check_eq("rst_frame_count", frame_count, 0);
    check_eq("rst_level", fifo_level, 0);
    reset_n = 1'b1;
    step();
    check_eq("post_rst_in_ready", sif.in_ready, 1);

    // Full frame, no gaps, consumer always ready
    sif.out_ready = 1'b1;
    send_seq(FRAME, 0);
    wait_out(FRAME, 100);
    check_eq("frame1_count", frame_count, 1);

    // Fill with 0x001..0x008 while stalled
    sif.out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) send(PW'(i), 0);
    check_eq("fill_level", fifo_level, DEPTH);
    check_eq("fill_in_ready", sif.in_ready, 0);
    sif.pixel_in = 12'h009;
    sif.in_valid = 1'b1;
    step();
    check_eq("ninth_rejected_level", fifo_level, DEPTH);
    // Read and attempted write in the same cycle while full
    sif.out_ready = 1'b1;
    check_eq("full_rd_in_ready", sif.in_ready, 0);
    step();
    sif.in_valid = 1'b0;
    check_eq("full_rd_level", fifo_level, DEPTH - 1);
    check_eq("full_rd_in_ready_after", sif.in_ready, 1);
    wait_out(FRAME + DEPTH, 100);
    check_eq("drained_level", fifo_level, 0);

    // Empty FIFO: written pixel appears only after the edge
    sif.pixel_in = 12'hABC;
    sif.in_valid = 1'b1;
    check_eq("empty_same_cycle_valid", sif.out_valid, 0);
    step();
    sif.in_valid = 1'b0;
    check_eq("empty_next_valid", sif.out_valid, 1);
    check_eq("empty_next_pixel", sif.pixel_out, 12'hABC);
    wait_out(FRAME + DEPTH + 1, 20);

    // Three frames with random input gaps and random consumer stalls
    do_reset();
    drv_done = 1'b0;
    fork
      begin
        send_seq(3 * FRAME, 30);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          sif.out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    sif.out_ready = 1'b1;
    wait_out(3 * FRAME, 200);
    check_eq("rand_frame_count", frame_count, 3);

    // Reset in the middle of frame 2 with pixels buffered
    do_reset();
    send_seq(FRAME + 57, 0);
    wait_out(FRAME + 57, 100);
    sif.out_ready = 1'b0;
    send_seq(3, 0);
    check_eq("pre_rst_level", fifo_level, 3);
    check_eq("pre_rst_frame_count", frame_count, 1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", sif.out_valid, 0);
    check_eq("mid_rst_in_ready", sif.in_ready, 0);
    check_eq("mid_rst_frame_count", frame_count, 0);
    check_eq("mid_rst_level", fifo_level, 0);
    exp_q.delete();
    out_idx = 0;
    step();
    step();
    reset_n = 1'b1;
    step();
    send(12'h5A5, 0);
    check_eq("restart_valid", sif.out_valid, 1);
    check_eq("restart_pixel", sif.pixel_out, 12'h5A5);
    check_eq("restart_sof", sif.out_sof, 1);
    sif.out_ready = 1'b1;
    wait_out(1, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crop_stream_framer.md
# crop_stream_framer

Elastic framing stage directly downstream of the crop filter. It accepts the cropped pixel stream through a valid/ready handshake and buffers it in a small synchronous FIFO. It re-emits each pixel with frame and line sideband flags (start-of-frame, end-of-line, end-of-frame) so later stages can consume the OUT_ROWS x OUT_COLS window without their own coordinate counters. It also counts completed frames.

## Interface
Parameters:
- PIXEL_BIT_WIDTH, 12, pixel data width.
- OUT_ROWS, 20, rows per cropped frame.
- OUT_COLS, 20, columns per cropped frame.
- FIFO_DEPTH, 8, buffer entries; power of two, >= 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- pixel_in  in  PIXEL_BIT_WIDTH  cropped pixel from the crop filter.
- in_valid  in  1  pixel_in is valid (crop filter out_valid).
- in_ready  out  1  buffer can accept a pixel this cycle (drives the crop filter out_ready).
- pixel_out  out  PIXEL_BIT_WIDTH  head-of-FIFO pixel.
- out_valid  out  1  pixel_out and the flags are valid.
- out_ready  in  1  consumer accepts this cycle.
- out_sof  out  1  head pixel is (row 0, col 0).
- out_eol  out  1  head pixel is col OUT_COLS-1.
- out_eof  out  1  head pixel is (row OUT_ROWS-1, col OUT_COLS-1).
- frame_count  out  16  number of completed frames; wraps modulo 2^16.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy, 0..FIFO_DEPTH.

## Operation
- Write occurs when in_valid && in_ready. Read occurs when out_valid && out_ready.
- in_ready = !full && reset_n. in_ready is forced low while reset_n is low.
- out_valid = !empty. pixel_out is the memory entry at the read pointer (first-word fall-through).
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide, with the MSB used as the wrap bit.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- When full, in_ready = 0 even if a read occurs in the same cycle. There is no pass-through write while full.
- When empty, no read occurs. A same-cycle write does not bypass to the output.
- A simultaneous read and write at any level 1..FIFO_DEPTH-1 leaves fifo_level unchanged.
- Output coordinate counters col (0..OUT_COLS-1) and row (0..OUT_ROWS-1) advance only on a read handshake.
  - col increments on each read.
  - At col == OUT_COLS-1, col goes to 0 and row increments.
  - At row == OUT_ROWS-1 with col == OUT_COLS-1, both go to 0 and frame_count increments.
- Flags are combinational from col/row: sof = (row==0 && col==0); eol = (col==OUT_COLS-1); eof = eol && (row==OUT_ROWS-1).
- Flags are meaningful only while out_valid = 1. Flags and pixel_out hold stable while out_valid && !out_ready.
- Framing is positional: the block trusts that upstream delivers exactly OUT_ROWS*OUT_COLS pixels per frame. There is no resynchronisation input.

## Timing
- Reset (async assert, release synchronous to clk):
  - pointers, col, row, frame_count, fifo_level all 0.
  - out_valid = 0, in_ready = 0 while asserted.
  - pixel_out is don't-care.
- Reset asserted mid-frame discards buffered pixels and restarts framing at (0,0). frame_count clears to 0.
- Latency: a pixel written at rising edge N drives out_valid = 1 immediately after edge N (one-cycle write-to-read latency). The earliest read handshake is in cycle N+1.
- Throughput: one pixel per cycle sustained when out_ready stays high.
- frame_count updates on the edge that completes the eof read handshake.

## Structure
- Shared package: pixel width default, and the frame flag bundle typedef (sof, eol, eof). The crop filter and later stages reuse it.
- Sub-module: `pixel_sync_fifo`, a parameterised width/depth FWFT FIFO with level output. The framing counters live in the top level.
- Memory is a register array; no vendor RAM.

## Test plan
- Reset then stream a 20x20 frame with out_ready = 1 and no input gaps:
  - 400 outputs in order.
  - sof on output 0 only; eol on outputs 19, 39, …, 399; eof on output 399 only.
  - frame_count = 1.
- Write 8 pixels 0x001..0x008 with out_ready = 0:
  - fifo_level = 8 and in_ready = 0.
  - The 9th in_valid is not accepted.
  - Raising out_ready drains 0x001..0x008 in order.
- Full FIFO, out_ready = 1 and in_valid = 1 in the same cycle:
  - one read and no write.
  - fifo_level = 7 on the next cycle, and in_ready = 1 only then.
- Empty FIFO, write 0xABC:
  - out_valid = 1 with pixel_out = 0xABC on the next cycle, not in the same cycle.
- Random in_valid/out_ready over 3 frames:
  - output data equals input order.
  - flags match positions.
  - frame_count = 3.
  - fifo_level never exceeds 8.
- Assert reset_n low after 57 pixels of frame 2:
  - immediately out_valid = 0, in_ready = 0, frame_count = 0.
  - after release, the first output carries sof.
